// File: rtl/rv_mem_pkg.sv
// Shared definitions for the RV32 instruction memory: fetch FSM states,
// the canonical NOP word and the word range check used on fetch addresses.
package rv_mem_pkg;

    localparam logic [31:0] NOP_RV32 = 32'h00000013;

    typedef enum logic [1:0] {
        BOOT = 2'b00,
        RUN  = 2'b01
    } imem_state_t;

    // Widened so that addr+3 can never wrap for any address width up to 64 bits.
    function automatic logic word_in_range(input logic [64:0] addr, input logic [64:0] depth);
        return (addr + 65'd3) < depth;
    endfunction

endpackage

// File: rtl/imem_byte_array.sv
// Byte-wide storage with a 4-byte little-endian write port and a
// 4-byte combinational read port; contents are never reset.
module imem_byte_array #(
    parameter int DEPTH_BYTES = 64,
    parameter int AW          = 6
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [7:0] mem [DEPTH_BYTES];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int k = 0; k < 4; k++) begin
                mem[waddr + AW'(k)] <= wdata[8*k +: 8];
            end
        end
    end

    always_comb begin
        rdata = '0;
        for (int k = 0; k < 4; k++) begin
            rdata[8*k +: 8] = mem[raddr + AW'(k)];
        end
    end

endmodule

// File: rtl/instr_mem_fetch.sv
// Boot-loadable instruction memory with a valid/ready fetch port and a
// single-entry registered response (1-cycle latency, NOP on error).
module instr_mem_fetch
    import rv_mem_pkg::*;
#(
    parameter int          ADDR_W      = 32,
    parameter int          DEPTH_BYTES = 64,
    parameter logic [31:0] NOP_INSTR   = NOP_RV32,
    parameter bit          ALIGN_CHECK = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [31:0]       ld_data,
    input  logic              ld_done,
    output logic              ld_err,
    output logic              boot_busy,
    input  logic              fetch_valid,
    input  logic [ADDR_W-1:0] fetch_pc,
    output logic              fetch_ready,
    output logic              instr_valid,
    output logic [31:0]       instr,
    output logic              instr_err,
    input  logic              instr_ready
);

    localparam int MEM_AW = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;

    imem_state_t       state;
    imem_state_t       state_next;

    logic              ld_in_range;
    logic              mem_we;
    logic [MEM_AW-1:0] mem_waddr;
    logic [MEM_AW-1:0] mem_raddr;
    logic [31:0]       mem_rdata;

    logic              fetch_misaligned;
    logic              fetch_in_range;
    logic              fetch_bad;
    logic              fetch_accept;

    // Loads address whole words; the low two address bits are dropped.
    assign ld_in_range = (65'(ld_addr) < 65'(DEPTH_BYTES));
    assign mem_we      = (state == BOOT) && ld_en && ld_in_range;
    assign mem_waddr   = ld_addr[MEM_AW-1:0] & ~MEM_AW'(3);

    assign fetch_misaligned = ALIGN_CHECK && (fetch_pc[1:0] != 2'b00);
    assign fetch_in_range   = word_in_range(65'(fetch_pc), 65'(DEPTH_BYTES));
    assign fetch_bad        = fetch_misaligned || !fetch_in_range;
    assign mem_raddr        = fetch_pc[MEM_AW-1:0] & ~MEM_AW'(3);
    assign fetch_accept     = fetch_valid && fetch_ready;

    imem_byte_array #(
        .DEPTH_BYTES(DEPTH_BYTES),
        .AW         (MEM_AW)
    ) u_array (
        .clk  (clk),
        .we   (mem_we),
        .waddr(mem_waddr),
        .wdata(ld_data),
        .raddr(mem_raddr),
        .rdata(mem_rdata)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    // RUN is terminal; only reset leaves it. The unused encoding falls back to BOOT.
    always_comb begin
        state_next  = BOOT;
        boot_busy   = 1'b0;
        fetch_ready = 1'b0;
        case (state)
            BOOT: begin
                boot_busy  = 1'b1;
                state_next = ld_done ? RUN : BOOT;
            end
            RUN: begin
                state_next  = RUN;
                fetch_ready = !instr_valid || instr_ready;
            end
            default: begin
                state_next = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            instr_valid <= 1'b0;
            instr       <= NOP_INSTR;
            instr_err   <= 1'b0;
        end else if (fetch_accept) begin
            instr_valid <= 1'b1;
            instr       <= fetch_bad ? NOP_INSTR : mem_rdata;
            instr_err   <= fetch_bad;
        end else if (instr_ready) begin
            instr_valid <= 1'b0;
        end
    end

    // Sticky: any load outside BOOT or beyond the array flags the loader.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ld_err <= 1'b0;
        end else if (ld_en && ((state != BOOT) || !ld_in_range)) begin
            ld_err <= 1'b1;
        end
    end

endmodule

// File: doc/instr_mem_fetch.md
Name: instr_mem_fetch

Overview:
- Parametrised, byte-addressable, little-endian instruction memory with a boot-load write port and a valid/ready fetch interface.
- After reset it sits in BOOT and accepts 32-bit program words from the loader. On `ld_done` it moves to RUN and serves instruction fetches with a 1-cycle registered latency.
- Sits between the PC/fetch stage and decode in the single-cycle/pipelined RV32 datapath.
- Replaces hard-coded program initialisation with a runtime load path and error signalling.

Parameters:
- ADDR_W, 32, width of PC and load address.
- DEPTH_BYTES, 64, memory size in bytes; must be a multiple of 4 and ≥ 4.
- NOP_INSTR, 32'h00000013, word returned on an error response (addi x0,x0,0).
- ALIGN_CHECK, 1, when 1 a PC with PC[1:0] != 0 is an error; when 0 the low 2 bits are ignored (word-aligned read).

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- ld_en  in  1  load-word strobe; honoured only in BOOT.
- ld_addr  in  ADDR_W  byte address of the word being loaded; low 2 bits ignored.
- ld_data  in  32  word to load; byte 0 = ld_data[7:0].
- ld_done  in  1  end-of-load pulse; BOOT→RUN.
- ld_err  out  1  sticky: a load was out of range or arrived outside BOOT.
- boot_busy  out  1  high while in BOOT.
- fetch_valid  in  1  fetch request present.
- fetch_pc  in  ADDR_W  byte address of requested instruction.
- fetch_ready  out  1  request accepted this cycle when fetch_valid & fetch_ready.
- instr_valid  out  1  response word valid.
- instr  out  32  {mem[a+3],mem[a+2],mem[a+1],mem[a]}.
- instr_err  out  1  response is an error (misaligned or out of range); instr = NOP_INSTR.
- instr_ready  in  1  consumer accepts response.

Behaviour:
- States: BOOT, RUN. 2-bit encoding; the unused code returns to BOOT.
- Reset (async, reset_n=0):
  - state=BOOT, instr_valid=0, instr=NOP_INSTR, instr_err=0, ld_err=0.
  - boot_busy=1, fetch_ready=0.
  - Memory contents are not cleared. Locations never loaded read as X in simulation.
- BOOT:
  - On ld_en, write bytes ld_data[8k+7:8k] to mem[{ld_addr[ADDR_W-1:2],2'b00}+k], k=0..3, at the clock edge.
  - ld_addr ≥ DEPTH_BYTES: write suppressed, ld_err←1.
  - ld_done: state→RUN on the next edge. ld_en and ld_done in the same cycle: the write completes, then the transition happens.
  - fetch_ready=0 throughout. Any fetch_valid is ignored.
- RUN:
  - ld_en sets ld_err←1 and does not write.
  - ld_done is ignored.
  - No path back to BOOT except reset.
- fetch_ready = (state==RUN) & (~instr_valid | instr_ready). This is a single-entry output register with no extra buffering.
- Accept (fetch_valid & fetch_ready) at edge N produces instr_valid=1 with data after edge N, i.e. 1-cycle latency.
- Back-to-back accepts with instr_ready held high give one word per cycle.
- Error classification at accept:
  - ALIGN_CHECK & fetch_pc[1:0]!=0 → misaligned.
  - fetch_pc+3 ≥ DEPTH_BYTES, computed at ADDR_W+1 bits so it cannot wrap → out of range.
  - Either condition: instr=NOP_INSTR, instr_err=1. Otherwise instr_err=0.
- Output hold: instr_valid & ~instr_ready keeps instr, instr_err and instr_valid stable and deasserts fetch_ready.
- Response consumed with no new accept: instr_valid→0. instr retains its last value.
- No combinational path from fetch_valid or fetch_pc to any output. fetch_ready depends only on state, instr_valid and instr_ready.
- ld_err clears only on reset.
- Reset asserted mid-response: instr_valid drops immediately (asynchronously). A pending response is discarded.

Decomposition:
- Shared package rv_mem_pkg holds:
  - localparam NOP_RV32 = 32'h00000013;
  - typedef enum {BOOT, RUN} imem_state_t;
  - a function word_in_range(addr, depth).
- One sub-module, imem_byte_array: a DEPTH_BYTES×8 array with a 4-byte write port and a 4-byte combinational read. The top handles the FSM, the error check and the output register.

Test Plan:
- Load 0x00940333 @0, 0x413903B3 @4, pulse ld_done, fetch pc=0 then pc=4 with instr_ready=1. Expect instr=0x00940333 then 0x413903B3 on consecutive cycles, instr_err=0, mem[0]=0x33.
- Fetch during BOOT (fetch_valid=1, pc=0). Expect fetch_ready=0 and no instr_valid until after ld_done.
- Fetch pc=2 with ALIGN_CHECK=1. Expect instr=0x00000013, instr_err=1. With ALIGN_CHECK=0, pc=2 returns the word at 0.
- Fetch pc=60 (ok) and pc=64 (DEPTH_BYTES=64). Expect the word at 60 with err=0, then NOP with err=1. Load ld_addr=64 in BOOT → ld_err=1.
- Hold instr_ready=0 for 3 cycles after a response. Expect instr stable, fetch_ready=0. Release it, expect the next accept in the same cycle.
- Assert reset_n=0 mid-stream. Expect instr_valid=0 and boot_busy=1 immediately, and ld_err cleared.
